// File: rtl/qeciphy_pkg.sv
// Shared definitions for the QECIPHY receive word aligner: comma symbol,
// per-lane aligner states and the status bundle a lane reports upward.
package qeciphy_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;

  typedef enum logic [2:0] {
    ST_SEARCH,
    ST_SLIDE,
    ST_WAIT,
    ST_CHECK,
    ST_LOCKED,
    ST_FAIL
  } aligner_state_e;

  typedef struct packed {
    logic       aligned;
    logic       fail;
    logic       rxslide;
    logic [7:0] slide_cnt;
  } lane_status_t;

endpackage

// File: rtl/qeciphy_rx_lane_aligner.sv
// One lane of comma alignment: hunts for K28.5 in byte 0, pulses rxslide to
// shift the transceiver's byte boundary, and declares/drops lock.
module qeciphy_rx_lane_aligner
  import qeciphy_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int LOCK_COUNT     = 8,
  parameter int ERR_LIMIT      = 4,
  parameter int MAX_SLIDES     = 2*DATA_W,
  parameter int SLIDE_WAIT     = 64,
  parameter int SEARCH_TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [DATA_W/8-1:0]   ctrl_i,
  input  logic                  sliderdy_i,
  output lane_status_t          status_o
);

  localparam int BYTES  = DATA_W/8;
  localparam int IDLE_W = $clog2(SEARCH_TIMEOUT+1);
  localparam int WAIT_W = $clog2(SLIDE_WAIT+1);
  localparam int GOOD_W = $clog2(LOCK_COUNT+1);
  localparam int ERR_W  = $clog2(ERR_LIMIT+1);

  aligner_state_e      state_q;
  logic [IDLE_W-1:0]   idle_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [GOOD_W-1:0]   good_q;
  logic [ERR_W-1:0]    err_q;
  logic [7:0]          slide_cnt_q, slide_cnt_d;
  logic                rxslide_q, aligned_q, fail_q;

  logic [BYTES-1:0]    comma;
  logic                misplaced, good, idle_to;

  always_comb begin
    comma = '0;
    for (int k = 0; k < BYTES; k++)
      comma[k] = ctrl_i[k] && (data_i[k*8 +: 8] == K28_5);
  end

  // A comma anywhere past byte 0 means the boundary is wrong, even if byte 0 also matches.
  assign misplaced   = |comma[BYTES-1:1];
  assign good        = comma[0] && !misplaced;
  assign idle_to     = !(|comma) && (idle_q == IDLE_W'(SEARCH_TIMEOUT-1));
  assign slide_cnt_d = (slide_cnt_q == 8'hFF) ? slide_cnt_q : slide_cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst || restart_i) begin
      state_q     <= ST_SEARCH;
      idle_q      <= '0;
      wait_q      <= '0;
      good_q      <= '0;
      err_q       <= '0;
      slide_cnt_q <= '0;
      rxslide_q   <= 1'b0;
      aligned_q   <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      rxslide_q <= 1'b0;
      case (state_q)
        ST_SEARCH: begin
          if (misplaced || idle_to) begin
            state_q     <= ST_SLIDE;
            rxslide_q   <= 1'b1;
            slide_cnt_q <= slide_cnt_d;
            idle_q      <= '0;
          end else if (good) begin
            idle_q <= '0;
            good_q <= GOOD_W'(1);
            if (LOCK_COUNT == 1) begin
              state_q   <= ST_LOCKED;
              aligned_q <= 1'b1;
              err_q     <= '0;
            end else begin
              state_q <= ST_CHECK;
            end
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
        ST_SLIDE: begin
          state_q <= ST_WAIT;
          wait_q  <= '0;
        end
        ST_WAIT: begin
          // Data is meaningless while the transceiver is re-slipping.
          if (sliderdy_i || (wait_q == WAIT_W'(SLIDE_WAIT-1))) begin
            if (slide_cnt_q == 8'(MAX_SLIDES)) begin
              state_q <= ST_FAIL;
              fail_q  <= 1'b1;
            end else begin
              state_q <= ST_SEARCH;
              idle_q  <= '0;
            end
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ST_CHECK: begin
          if (misplaced) begin
            state_q     <= ST_SLIDE;
            rxslide_q   <= 1'b1;
            slide_cnt_q <= slide_cnt_d;
            idle_q      <= '0;
          end else if (good) begin
            idle_q <= '0;
            if (good_q == GOOD_W'(LOCK_COUNT-1)) begin
              state_q   <= ST_LOCKED;
              aligned_q <= 1'b1;
              err_q     <= '0;
            end else begin
              good_q <= good_q + 1'b1;
            end
          end else if (idle_to) begin
            state_q <= ST_SEARCH;
            idle_q  <= '0;
            good_q  <= '0;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (misplaced) begin
            if (err_q == ERR_W'(ERR_LIMIT-1)) begin
              state_q     <= ST_SEARCH;
              aligned_q   <= 1'b0;
              slide_cnt_q <= '0;
              err_q       <= '0;
              good_q      <= '0;
              idle_q      <= '0;
            end else begin
              err_q <= err_q + 1'b1;
            end
          end else if (good) begin
            err_q <= '0;
          end
        end
        ST_FAIL: ;
        default: state_q <= ST_SEARCH;
      endcase
    end
  end

  assign status_o.aligned   = aligned_q;
  assign status_o.fail      = fail_q;
  assign status_o.rxslide   = rxslide_q;
  assign status_o.slide_cnt = slide_cnt_q;

endmodule

// File: rtl/qeciphy_rx_word_aligner.sv
// Multi-lane receive word aligner: an independent aligner per GTY lane plus
// a registered all-lanes-locked flag.
module qeciphy_rx_word_aligner
  import qeciphy_pkg::*;
#(
  parameter int NUM_LANES      = 1,
  parameter int DATA_W         = 32,
  parameter int LOCK_COUNT     = 8,
  parameter int ERR_LIMIT      = 4,
  parameter int MAX_SLIDES     = 2*DATA_W,
  parameter int SLIDE_WAIT     = 64,
  parameter int SEARCH_TIMEOUT = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          restart,
  input  logic [NUM_LANES*DATA_W-1:0]   rx_data,
  input  logic [NUM_LANES*DATA_W/8-1:0] rx_ctrl,
  input  logic [NUM_LANES-1:0]          rxsliderdy,
  output logic [NUM_LANES-1:0]          rxslide,
  output logic [NUM_LANES-1:0]          aligned,
  output logic [NUM_LANES-1:0]          fail,
  output logic                          all_aligned,
  output logic [NUM_LANES*8-1:0]        slide_cnt
);

  localparam int BYTES = DATA_W/8;

  lane_status_t st [NUM_LANES];
  logic         all_aligned_q;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    qeciphy_rx_lane_aligner #(
      .DATA_W         (DATA_W),
      .LOCK_COUNT     (LOCK_COUNT),
      .ERR_LIMIT      (ERR_LIMIT),
      .MAX_SLIDES     (MAX_SLIDES),
      .SLIDE_WAIT     (SLIDE_WAIT),
      .SEARCH_TIMEOUT (SEARCH_TIMEOUT)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .restart_i  (restart),
      .data_i     (rx_data[n*DATA_W +: DATA_W]),
      .ctrl_i     (rx_ctrl[n*BYTES +: BYTES]),
      .sliderdy_i (rxsliderdy[n]),
      .status_o   (st[n])
    );
    assign rxslide[n]          = st[n].rxslide;
    assign aligned[n]          = st[n].aligned;
    assign fail[n]             = st[n].fail;
    assign slide_cnt[n*8 +: 8] = st[n].slide_cnt;
  end

  // Lags the per-lane flags by one cycle.
  always_ff @(posedge clk) begin
    if (rst) all_aligned_q <= 1'b0;
    else     all_aligned_q <= &aligned;
  end

  assign all_aligned = all_aligned_q;

endmodule
